// File: rtl/pwm_clk_pkg.sv
// Shared clocking/reset types and defaults for the PWM clock domain.
// Holds the lock-FSM encoding and the counter sizing helper.
package pwm_clk_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } lock_state_e;

    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RST_HOLD_CYCLES    = 16;
    localparam int DEF_TICK_DIV           = 12;
    localparam int DEF_LOST_CNT_W         = 8;

    // Width to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flop synchronizer with synchronous active-low reset.
// Used for PLL lock and, later, the PWM external inputs.
module sync_2ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_gen.sv
// Qualifies PLL lock into a clean system reset, a divided tick enable
// and sticky/counted loss-of-lock reporting.
module pll_lock_reset_gen
    import pwm_clk_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES,
    parameter int TICK_DIV           = DEF_TICK_DIV,
    parameter int LOST_CNT_W         = DEF_LOST_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  clr_lost,
    output logic                  sys_rst_n,
    output logic                  locked,
    output logic                  tick,
    output logic                  lock_lost,
    output logic [LOST_CNT_W-1:0] lost_count,
    output logic [STATE_W-1:0]    state_o
);

    localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
    localparam int HW = cnt_w(RST_HOLD_CYCLES);
    localparam int PW = cnt_w(TICK_DIV);

    localparam logic [SW-1:0] STAB_MAX  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    lock_state_e           state_q, state_d;
    logic [SW-1:0]         stab_q, stab_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic                  srst_q, srst_d;
    logic                  locked_q, locked_d;
    logic                  tick_q, tick_d;
    logic                  lost_q, lost_d;
    logic [LOST_CNT_W-1:0] cnt_q, cnt_d;
    logic [LOST_CNT_W-1:0] cnt_base;
    logic                  lock_s;
    logic                  loss;

    sync_2ff #(
        .STAGES(2),
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        stab_d  = '0;
        hold_d  = '0;
        presc_d = '0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s)                state_d = WAIT_LOCK;
                else if (stab_q == STAB_MAX) state_d = HOLD;
                else                         stab_d  = stab_q + 1'b1;
            end
            HOLD: begin
                if (!lock_s)                state_d = WAIT_LOCK;
                else if (hold_q == HOLD_MAX) state_d = RUN;
                else                         hold_d  = hold_q + 1'b1;
            end
            RUN: begin
                if (!lock_s)                  state_d = WAIT_LOCK;
                else if (presc_q != PRESC_MAX) presc_d = presc_q + 1'b1;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // A loss coinciding with a clear counts as the first event after it.
    always_comb begin
        loss     = (state_q == RUN) && !lock_s;
        cnt_base = clr_lost ? '0 : cnt_q;
        lost_d   = clr_lost ? 1'b0 : lost_q;
        cnt_d    = cnt_base;
        if (loss) begin
            lost_d = 1'b1;
            cnt_d  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
        end
        srst_d   = (state_d == RUN);
        locked_d = (state_d == RUN);
        tick_d   = (state_q == RUN) && (state_d == RUN)
                   && (presc_q == PRESC_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            stab_q   <= '0;
            hold_q   <= '0;
            presc_q  <= '0;
            srst_q   <= 1'b0;
            locked_q <= 1'b0;
            tick_q   <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            stab_q   <= stab_d;
            hold_q   <= hold_d;
            presc_q  <= presc_d;
            srst_q   <= srst_d;
            locked_q <= locked_d;
            tick_q   <= tick_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sys_rst_n  = srst_q;
    assign locked     = locked_q;
    assign tick       = tick_q;
    assign lock_lost  = lost_q;
    assign lost_count = cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Directed bench: LOCK_STABLE=8, RST_HOLD=4, TICK_DIV=3 (and 1), LOST_CNT_W=2.
// Table of {inputs, cycles, expected outputs} plus hand sequences.
module tb_pll_lock_reset_gen;

    logic       clk;
    logic       rst_n;
    logic       pll_lock;
    logic       clr_lost;
    logic       sys_rst_n,  sys_rst_n1;
    logic       locked,     locked1;
    logic       tick,       tick1;
    logic       lock_lost,  lock_lost1;
    logic [1:0] lost_count, lost_count1;
    logic [1:0] state_o,    state_o1;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_reset_gen #(
        .LOCK_STABLE_CYCLES(8),
        .RST_HOLD_CYCLES   (4),
        .TICK_DIV          (3),
        .LOST_CNT_W        (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .clr_lost  (clr_lost),
        .sys_rst_n (sys_rst_n),
        .locked    (locked),
        .tick      (tick),
        .lock_lost (lock_lost),
        .lost_count(lost_count),
        .state_o   (state_o)
    );

    pll_lock_reset_gen #(
        .LOCK_STABLE_CYCLES(8),
        .RST_HOLD_CYCLES   (4),
        .TICK_DIV          (1),
        .LOST_CNT_W        (2)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .clr_lost  (clr_lost),
        .sys_rst_n (sys_rst_n1),
        .locked    (locked1),
        .tick      (tick1),
        .lock_lost (lock_lost1),
        .lost_count(lost_count1),
        .state_o   (state_o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       lock;
        logic       clr;
        int         n;
        logic       srst;
        logic       lkd;
        logic       tk;
        logic       tk1;
        logic       lost;
        logic [1:0] cnt;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[30];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        clr_lost = 1'b0;

        //           rst   lock  clr  n   srst  lkd   tk    tk1   lost  cnt    st
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[13] = '{1'b1, 1'b1, 1'b0,12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[21] = '{1'b1, 1'b1, 1'b0,13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[24] = '{1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        vecs[26] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        vecs[27] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[28] = '{1'b1, 1'b1, 1'b0,12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        vecs[29] = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3};

        for (int i = 0; i < 30; i++) begin
            rst_n    = vecs[i].rst_n;
            pll_lock = vecs[i].lock;
            clr_lost = vecs[i].clr;
            repeat (vecs[i].n) step();
            check($sformatf("v%0d.sys_rst_n", i), 32'(sys_rst_n), 32'(vecs[i].srst));
            check($sformatf("v%0d.locked", i), 32'(locked), 32'(vecs[i].lkd));
            check($sformatf("v%0d.tick", i), 32'(tick), 32'(vecs[i].tk));
            check($sformatf("v%0d.tick_div1", i), 32'(tick1), 32'(vecs[i].tk1));
            check($sformatf("v%0d.lock_lost", i), 32'(lock_lost), 32'(vecs[i].lost));
            check($sformatf("v%0d.lost_count", i), 32'(lost_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d.state", i), 32'(state_o), 32'(vecs[i].st));
        end
        clr_lost = 1'b0;

        // Repeated RUN-to-loss cycles: count saturates at 3.
        for (int i = 1; i <= 6; i++) begin
            pll_lock = 1'b0;
            repeat (3) step();
            check($sformatf("sat%0d.lost_count", i), 32'(lost_count),
                  (i > 3) ? 32'd3 : 32'(i));
            check($sformatf("sat%0d.lock_lost", i), 32'(lock_lost), 32'd1);
            check($sformatf("sat%0d.state_wait", i), 32'(state_o), 32'd0);
            pll_lock = 1'b1;
            repeat (15) step();
            check($sformatf("sat%0d.state_run", i), 32'(state_o), 32'd3);
            check($sformatf("sat%0d.tick_div1_first", i), 32'(tick1), 32'd0);
            step();
            check($sformatf("sat%0d.tick_div1_run", i), 32'(tick1), 32'd1);
        end

        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        check("clr.lock_lost", 32'(lock_lost), 32'd0);
        check("clr.lost_count", 32'(lost_count), 32'd0);
        check("clr.state", 32'(state_o), 32'd3);

        // Clear on the loss edge: the loss wins.
        pll_lock = 1'b0;
        step();
        step();
        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        check("clrloss.lock_lost", 32'(lock_lost), 32'd1);
        check("clrloss.lost_count", 32'(lost_count), 32'd1);
        check("clrloss.sys_rst_n", 32'(sys_rst_n), 32'd0);
        check("clrloss.state", 32'(state_o), 32'd0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst.lock_lost", 32'(lock_lost), 32'd0);
        check("rst.lost_count", 32'(lost_count), 32'd0);
        check("rst.state", 32'(state_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset_gen.md
Name: pll_lock_reset_gen

Overview:
- Sits directly downstream of the iCE40 clock source (SB_HFOSC to SB_PLL40_CORE) and consumes the PLL output clock and its LOCK signal.
- Produces a clean synchronous system reset for the PWM core. Reset is released only after LOCK has been stable and a hold period has elapsed.
- Generates a divided single-cycle tick enable for the PWM counters.
- Reports loss of lock through a sticky flag and a saturating loss counter.

Parameters:
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before the reset hold phase begins (>=1).
- RST_HOLD_CYCLES, 16, cycles sys_rst_n stays low after lock is deemed stable (>=1).
- TICK_DIV, 12, tick period in clk cycles. 12 gives 1 MHz from 12 MHz. Must be >=1.
- LOST_CNT_W, 8, width of lost_count.

Ports:
- clk  in  1  PLL output clock (PLLOUTGLOBAL).
- rst_n  in  1  synchronous active-low reset.
- pll_lock  in  1  PLL LOCK. Asynchronous to clk; must be synchronized.
- clr_lost  in  1  single-cycle pulse that clears lock_lost and lost_count.
- sys_rst_n  out  1  registered system reset for the PWM core, active-low.
- locked  out  1  high while in RUN.
- tick  out  1  one-cycle enable every TICK_DIV cycles while in RUN.
- lock_lost  out  1  sticky flag: lock dropped while in RUN.
- lost_count  out  LOST_CNT_W  number of RUN-to-loss events, saturating.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst_n=0 at an edge) forces the following, independent of pll_lock:
  - sync flops 0, state WAIT_LOCK, all counters 0.
  - sys_rst_n=0, locked=0, tick=0, lock_lost=0, lost_count=0.
- Synchronizer: pll_lock passes through 2 flops to give lock_s. All FSM decisions use lock_s only.
- State encoding: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3.
- WAIT_LOCK:
  - sys_rst_n=0, stable counter cleared.
  - lock_s=1 goes to STABLE.
- STABLE:
  - Counter increments each cycle lock_s=1.
  - lock_s=0 goes to WAIT_LOCK and clears the counter.
  - Once LOCK_STABLE_CYCLES cycles are counted, go to HOLD.
- HOLD:
  - sys_rst_n stays 0; hold counter counts RST_HOLD_CYCLES.
  - lock_s=0 goes to WAIT_LOCK. lock_lost is not set.
  - On completion, go to RUN.
- RUN:
  - sys_rst_n=1, locked=1, prescaler active.
  - lock_s=0 goes to WAIT_LOCK.
- Outputs are registered and change on the same edge as the state transition.
- Release latency: pll_lock first sampled high at edge 0 and held high, so sys_rst_n=1 and locked=1 after edge 2+LOCK_STABLE_CYCLES+RST_HOLD_CYCLES.
- Loss latency: pll_lock first sampled low at edge k while in RUN, so sys_rst_n=0, locked=0, tick=0 after edge k+2.
  - On the same edge, lock_lost is set and lost_count increments.
  - lost_count saturates at all-ones and does not wrap.
- clr_lost clears lock_lost and lost_count on the next edge. If clr_lost coincides with a loss event, the set wins: lock_lost=1 and lost_count=1.
- Tick:
  - The prescaler is 0 on RUN entry and counts 0..TICK_DIV-1 in RUN.
  - tick=1 for the cycle in which the prescaler equals TICK_DIV-1, so the first tick occurs TICK_DIV cycles after RUN entry.
  - TICK_DIV=1 gives tick=1 on every RUN cycle.
  - Prescaler is cleared on leaving RUN.
- Glitch on lock_s shorter than the stable window restarts qualification from zero.
- Reset asserted mid-RUN: sys_rst_n=0 on that edge. Re-qualification restarts from WAIT_LOCK.
- Counters are sized with $clog2 of their max value and are never compared beyond that max.

Decomposition:
- Shared package pwm_clk_pkg:
  - state enum and encoding constant.
  - default parameter values.
  - state_o width constant.
- One sub-module, sync_2ff: parameterizable-depth flop synchronizer with synchronous active-low reset. Reused later for the PWM external inputs.

Test Plan:
- LOCK_STABLE=8, RST_HOLD=4, TICK_DIV=3; pll_lock high from edge 0 -> sys_rst_n=1 and locked=1 after edge 14; tick after edges 17, 20, 23.
- Same params; pll_lock high for 5 cycles, low 1 cycle, then high -> qualification restarts; sys_rst_n rises 14 edges after the re-rise; lock_lost stays 0.
- In RUN, drop pll_lock at edge k -> sys_rst_n=0 and tick=0 after edge k+2; lock_lost=1, lost_count=1; re-lock gives full 14-cycle re-qualification.
- Six RUN-to-loss cycles with LOST_CNT_W=2 -> lost_count saturates at 3; clr_lost pulse gives 0/0; clr_lost on a loss edge gives lock_lost=1, lost_count=1.
- rst_n low for 1 cycle mid-RUN with pll_lock high -> all outputs at reset values next edge; sys_rst_n rises 14 edges after rst_n returns high.
- TICK_DIV=1 -> tick continuously high in RUN, low in every other state.
